// File: rtl/ad_da_sample_sequencer.sv
// ad_da_sample_sequencer: periodic AD7606 conversion scheduler that forwards one
// selected channel, converted to offset binary, to the DAC writer over req/ack.
module ad_da_sample_sequencer #(
  parameter int unsigned SAMPLE_DIV = 1000,
  parameter int unsigned TIMEOUT    = 4095,
  parameter int unsigned NUM_CH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  ch_sel,
  input  logic        clear_err,
  output logic        ad_start,
  input  logic        ad_valid,
  input  logic [2:0]  ad_ch,
  input  logic [15:0] ad_word,
  input  logic        ad_done,
  output logic        da_req,
  output logic [15:0] da_data,
  input  logic        da_ack,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err,
  output logic        miss_err,
  output logic [31:0] sample_cnt
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DATA = 2'd2,
    DA_REQ    = 2'd3
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [2:0]         ch_lat;
  logic               cap;

  logic               tick_c;
  logic               match_c;
  logic               set_ovr_c;
  logic               set_miss_c;
  logic               set_tmo_c;

  // Sample tick and event decode shared by the FSM and the status flags
  assign tick_c     = enable && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign match_c    = ad_valid && (ad_ch == ch_lat) && (32'(ad_ch) < NUM_CH);
  assign set_ovr_c  = tick_c && (state != IDLE);
  assign set_miss_c = (state == WAIT_DATA) && ad_done && !(cap || match_c);
  assign set_tmo_c  = (state == WAIT_DATA) && !ad_done &&
                      (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // Sample-period divider; disabled means parked at zero
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      div_cnt <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Transaction FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ad_start   <= 1'b0;
      da_req     <= 1'b0;
      da_data    <= 16'h0000;
      busy       <= 1'b0;
      sample_cnt <= 32'd0;
      tmo_cnt    <= '0;
      ch_lat     <= 3'd0;
      cap        <= 1'b0;
    end else begin
      ad_start <= 1'b0;
      case (state)
        IDLE: begin
          if (tick_c) begin
            ch_lat   <= ch_sel;
            cap      <= 1'b0;
            ad_start <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tmo_cnt <= '0;
          state   <= WAIT_DATA;
        end
        WAIT_DATA: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (match_c) begin
            da_data <= ad_word ^ 16'h8000;
            cap     <= 1'b1;
          end
          // ad_done takes priority over an expiring timeout
          if (ad_done) begin
            if (cap || match_c) begin
              da_req <= 1'b1;
              state  <= DA_REQ;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (set_tmo_c) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        DA_REQ: begin
          if (da_ack) begin
            da_req     <= 1'b0;
            sample_cnt <= sample_cnt + 32'd1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          da_req <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Sticky status flags; a set in the same cycle as clear_err wins
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      miss_err    <= 1'b0;
    end else begin
      if (clear_err) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
        miss_err    <= 1'b0;
      end
      if (set_ovr_c)  overrun     <= 1'b1;
      if (set_tmo_c)  timeout_err <= 1'b1;
      if (set_miss_c) miss_err    <= 1'b1;
    end
  end

endmodule
